// File: rtl/spi_cmd_sequencer.sv
// rtl/spi_cmd_sequencer.sv - SPI frame sequencer: command decode, register writes, prefetched reads onto MISO
module spi_cmd_sequencer #(
    parameter int ADDR_BITS  = 7,
    parameter int RD_TIMEOUT = 16,
    parameter int AUTO_INC   = 1
) (
    input  logic                 MClk,
    input  logic                 Rst_n,
    input  logic                 CSel_Active,
    input  logic                 CSel_Start,
    input  logic [7:0]           Rx_Byte,
    input  logic                 Rx_Byte_Valid,
    output logic [7:0]           Tx_Byte,
    output logic                 Tx_Load,
    output logic [ADDR_BITS-1:0] Reg_Addr,
    output logic [7:0]           Reg_Wr_Data,
    output logic                 Reg_Wr_En,
    output logic                 Reg_Rd_En,
    input  logic [7:0]           Reg_Rd_Data,
    input  logic                 Reg_Rd_Valid,
    input  logic                 Err_Clr,
    output logic                 Rd_Timeout_Flag,
    output logic                 Underrun_Flag,
    output logic [7:0]           Frame_Count
);

    localparam int CNT_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_WRITE, S_RD_REQ, S_RD_WAIT, S_RD_HOLD
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [ADDR_BITS-1:0] r_addr;
    logic [CNT_W-1:0]     r_cnt;
    logic [7:0]           r_tx_byte;
    logic                 r_tx_load;
    logic                 r_wr_en;
    logic [7:0]           r_wr_data;
    logic                 r_rd_timeout;
    logic                 r_underrun;
    logic [7:0]           r_frame_cnt;

    logic                 w_live;
    logic                 w_in_wait;
    logic                 w_rd_got;
    logic                 w_rd_tmo;
    logic                 w_rd_done;
    logic                 w_urun;
    logic [ADDR_BITS-1:0] w_addr_next;

    // A new frame start overrides everything, including a byte arriving in the same cycle
    assign w_live      = CSel_Active & ~CSel_Start;
    assign w_in_wait   = w_live && (r_state == S_RD_WAIT);
    assign w_rd_got    = w_in_wait && Reg_Rd_Valid;
    assign w_rd_tmo    = w_in_wait && !Reg_Rd_Valid && (r_cnt == CNT_W'(RD_TIMEOUT - 1));
    assign w_rd_done   = w_rd_got | w_rd_tmo;
    assign w_urun      = w_in_wait && !Reg_Rd_Valid && Rx_Byte_Valid;
    assign w_addr_next = (AUTO_INC != 0) ? r_addr + ADDR_BITS'(1) : r_addr;

    always_ff @(posedge MClk) begin
        if (!Rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (CSel_Start) begin
            w_next = S_CMD;
        end else if (!CSel_Active) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_CMD:     if (Rx_Byte_Valid) w_next = Rx_Byte[7] ? S_RD_REQ : S_WRITE;
                S_RD_REQ:  w_next = S_RD_WAIT;
                S_RD_WAIT: if (w_rd_done) w_next = S_RD_HOLD;
                S_RD_HOLD: if (Rx_Byte_Valid) w_next = S_RD_REQ;
                default:   w_next = r_state;
            endcase
        end
    end

    always_comb begin
        Reg_Rd_En = 1'b0;
        if (r_state == S_RD_REQ && w_live) begin
            Reg_Rd_En = 1'b1;
        end
    end

    always_ff @(posedge MClk) begin
        if (!Rst_n) begin
            r_addr       <= '0;
            r_cnt        <= '0;
            r_tx_byte    <= 8'h00;
            r_tx_load    <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_data    <= 8'h00;
            r_rd_timeout <= 1'b0;
            r_underrun   <= 1'b0;
            r_frame_cnt  <= 8'h00;
        end else begin
            r_wr_en   <= 1'b0;
            r_tx_load <= 1'b0;
            if (CSel_Start) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
            if (!CSel_Active) begin
                r_tx_byte <= 8'h00;
            end
            // Address advances the cycle after the write strobe so the strobe carries the old address
            if (r_wr_en) begin
                r_addr <= w_addr_next;
            end
            if (w_live && r_state == S_CMD && Rx_Byte_Valid) begin
                r_addr <= Rx_Byte[ADDR_BITS-1:0];
            end
            if (w_live && r_state == S_WRITE && Rx_Byte_Valid) begin
                r_wr_en   <= 1'b1;
                r_wr_data <= Rx_Byte;
            end
            if (r_state == S_RD_REQ) begin
                r_cnt <= '0;
            end else if (w_in_wait) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_rd_done) begin
                r_tx_load <= 1'b1;
                r_tx_byte <= w_rd_got ? Reg_Rd_Data : 8'hFF;
                r_addr    <= w_addr_next;
            end else if (w_urun) begin
                r_tx_load <= 1'b1;
                r_tx_byte <= 8'h00;
            end
            r_rd_timeout <= w_rd_tmo | (r_rd_timeout & ~Err_Clr);
            r_underrun   <= w_urun | (r_underrun & ~Err_Clr);
        end
    end

    assign Tx_Byte         = r_tx_byte;
    assign Tx_Load         = r_tx_load & CSel_Active;
    assign Reg_Addr        = r_addr;
    assign Reg_Wr_Data     = r_wr_data;
    assign Reg_Wr_En       = r_wr_en;
    assign Rd_Timeout_Flag = r_rd_timeout;
    assign Underrun_Flag   = r_underrun;
    assign Frame_Count     = r_frame_cnt;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// tb/tb_spi_cmd_sequencer.sv - self-checking bench for spi_cmd_sequencer
module tb_spi_cmd_sequencer;

    localparam int AB  = 7;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          csel_active, csel_start;
    logic [7:0]    rx_byte;
    logic          rx_valid;
    logic [7:0]    tx_byte;
    logic          tx_load;
    logic [AB-1:0] reg_addr;
    logic [7:0]    wr_data;
    logic          wr_en, rd_en;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic          err_clr;
    logic          tmo_flag, urun_flag;
    logic [7:0]    frame_count;

    spi_cmd_sequencer #(.ADDR_BITS(AB), .RD_TIMEOUT(TMO), .AUTO_INC(1)) dut (
        .MClk(clk), .Rst_n(rst_n), .CSel_Active(csel_active), .CSel_Start(csel_start),
        .Rx_Byte(rx_byte), .Rx_Byte_Valid(rx_valid), .Tx_Byte(tx_byte), .Tx_Load(tx_load),
        .Reg_Addr(reg_addr), .Reg_Wr_Data(wr_data), .Reg_Wr_En(wr_en), .Reg_Rd_En(rd_en),
        .Reg_Rd_Data(rd_data), .Reg_Rd_Valid(rd_valid), .Err_Clr(err_clr),
        .Rd_Timeout_Flag(tmo_flag), .Underrun_Flag(urun_flag), .Frame_Count(frame_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int            q_wr_cyc[$];
    logic [AB-1:0] q_wr_addr[$];
    logic [7:0]    q_wr_data[$];
    int            q_rd_cyc[$];
    logic [AB-1:0] q_rd_addr[$];
    int            q_tx_cyc[$];
    logic [7:0]    q_tx_data[$];
    int            n_both  = 0;
    int            n_txoff = 0;

    always @(negedge clk) begin
        if (wr_en) begin q_wr_cyc.push_back(cyc); q_wr_addr.push_back(reg_addr); q_wr_data.push_back(wr_data); end
        if (rd_en) begin q_rd_cyc.push_back(cyc); q_rd_addr.push_back(reg_addr); end
        if (tx_load) begin q_tx_cyc.push_back(cyc); q_tx_data.push_back(tx_byte); end
        if (wr_en && rd_en) n_both++;
        if (tx_load && !csel_active) n_txoff++;
    end

    int n_cmp = 0;
    int n_err = 0;
    int exp_frames = 0;

    logic [7:0] wdata[8];
    logic [7:0] rdata[8];
    int         lat[8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        q_wr_cyc.delete(); q_wr_addr.delete(); q_wr_data.delete();
        q_rd_cyc.delete(); q_rd_addr.delete(); q_tx_cyc.delete(); q_tx_data.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, output int c);
        rx_byte  = b;
        rx_valid = 1'b1;
        c        = cyc;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic start_frame();
        csel_active = 1'b1;
        csel_start  = 1'b1;
        tick();
        csel_start  = 1'b0;
        exp_frames  = (exp_frames + 1) % 256;
        tick();
    endtask

    task automatic end_frame();
        csel_active = 1'b0;
        tick();
        tick();
        chk("frame_end_tx_byte", tx_byte, 0);
        chk("frame_count", frame_count, exp_frames);
    endtask

    task automatic wait_rd(output int ok);
        ok = 0;
        for (int k = 0; k < 8 && ok == 0; k++) begin
            if (rd_en) ok = 1;
            else tick();
        end
    endtask

    function automatic int addr_at(input int a, input int i);
        return (a + i) % (1 << AB);
    endfunction

    task automatic do_write(input int a, input int n);
        int c;
        int rc[8];
        clear_q();
        start_frame();
        send_byte(8'(a), c);
        tick();
        for (int i = 0; i < n; i++) begin
            send_byte(wdata[i], rc[i]);
            repeat (1 + $urandom_range(0, 2)) tick();
        end
        end_frame();
        chk("wr_count", q_wr_cyc.size(), n);
        chk("wr_no_rd", q_rd_cyc.size(), 0);
        for (int i = 0; i < n; i++) begin
            chk("wr_addr", q_wr_addr[i], addr_at(a, i));
            chk("wr_data", q_wr_data[i], wdata[i]);
            chk("wr_latency", q_wr_cyc[i], rc[i] + 1);
        end
    endtask

    task automatic do_read(input int a, input int n);
        int c, ok, t;
        int hc[8];
        int vc[8];
        clear_q();
        start_frame();
        send_byte(8'h80 | 8'(a), c);
        hc[0] = c;
        for (int i = 0; i < n; i++) begin
            if (i > 0) send_byte(8'($urandom), hc[i]);
            wait_rd(ok);
            chk("rd_en_seen", ok, 1);
            repeat (lat[i]) tick();
            rd_data  = rdata[i];
            rd_valid = 1'b1;
            vc[i]    = cyc;
            tick();
            rd_valid = 1'b0;
            repeat (2) tick();
        end
        end_frame();
        chk("rd_count", q_rd_cyc.size(), n);
        chk("tx_count", q_tx_cyc.size(), n);
        chk("rd_no_wr", q_wr_cyc.size(), 0);
        chk("rd_no_timeout", tmo_flag, 0);
        chk("rd_no_underrun", urun_flag, 0);
        for (int i = 0; i < n; i++) begin
            chk("rd_addr", q_rd_addr[i], addr_at(a, i));
            chk("rd_en_cycle", q_rd_cyc[i], hc[i] + 1);
            chk("tx_data", q_tx_data[i], rdata[i]);
            chk("tx_latency", q_tx_cyc[i], vc[i] + 1);
        end
    endtask

    initial begin
        int ok, t, c, rc, vc;
        rst_n = 1'b0; csel_active = 1'b0; csel_start = 1'b0; rx_byte = 8'h00; rx_valid = 1'b0;
        rd_data = 8'h00; rd_valid = 1'b0; err_clr = 1'b0;
        repeat (3) tick();
        chk("rst_tx_byte", tx_byte, 0);
        chk("rst_tx_load", tx_load, 0);
        chk("rst_addr", reg_addr, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_frames", frame_count, 0);
        rst_n = 1'b1;
        tick();

        // reset while a read is outstanding
        clear_q();
        start_frame();
        send_byte(8'hAA, c);
        wait_rd(ok);
        chk("mid_rd_en_seen", ok, 1);
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        exp_frames = 0;
        chk("midrst_tx_byte", tx_byte, 0);
        chk("midrst_tx_load", tx_load, 0);
        chk("midrst_addr", reg_addr, 0);
        chk("midrst_wr_data", wr_data, 0);
        chk("midrst_rd_en", rd_en, 0);
        chk("midrst_flags", {tmo_flag, urun_flag}, 0);
        chk("midrst_frames", frame_count, 0);
        rst_n = 1'b1;
        tick();
        rd_data = 8'h5A; rd_valid = 1'b1;
        tick();
        rd_valid = 1'b0;
        repeat (3) tick();
        chk("midrst_late_valid_no_load", q_tx_cyc.size(), 0);
        csel_active = 1'b0;
        tick();

        // writes: directed 0x05 then wrap from 0x7F, then random
        wdata[0] = 8'hA1; wdata[1] = 8'hB2;
        do_write(5, 2);
        wdata[0] = 8'($urandom); wdata[1] = 8'($urandom);
        do_write(8'h7F, 2);
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 4; i++) wdata[i] = 8'($urandom);
            do_write(int'($urandom_range(0, 127)), int'($urandom_range(1, 4)));
        end

        // reads: directed 0x83 with 3-cycle latency, then random latencies including the limit
        rdata[0] = 8'h11; rdata[1] = 8'h22; lat[0] = 3; lat[1] = 3;
        do_read(3, 2);
        rdata[0] = 8'($urandom); lat[0] = TMO; rdata[1] = 8'($urandom); lat[1] = 1;
        do_read(8'h7F, 2);
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 3; i++) begin
                rdata[i] = 8'($urandom);
                lat[i]   = int'($urandom_range(1, TMO));
            end
            do_read(int'($urandom_range(0, 127)), 3);
        end

        // timeout, with Err_Clr colliding with the error cycle
        clear_q();
        start_frame();
        send_byte(8'h80 | 8'h40, c);
        wait_rd(ok);
        chk("tmo_rd_en_seen", ok, 1);
        t = cyc;
        repeat (TMO) tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tick();
        chk("tmo_tx_count", q_tx_cyc.size(), 1);
        chk("tmo_tx_data", q_tx_data[0], 8'hFF);
        chk("tmo_tx_cycle", q_tx_cyc[0], t + TMO + 1);
        chk("tmo_flag_set", tmo_flag, 1);
        chk("tmo_addr_adv", reg_addr, 8'h41);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("tmo_flag_cleared", tmo_flag, 0);
        end_frame();

        // underrun: host clocks the next byte before read data arrives
        clear_q();
        start_frame();
        send_byte(8'h80 | 8'h10, c);
        wait_rd(ok);
        chk("urun_rd_en_seen", ok, 1);
        repeat (2) tick();
        send_byte(8'h33, rc);
        repeat (2) tick();
        rd_data = 8'hC7; rd_valid = 1'b1; vc = cyc;
        tick();
        rd_valid = 1'b0;
        tick();
        chk("urun_flag_set", urun_flag, 1);
        chk("urun_tx_count", q_tx_cyc.size(), 2);
        chk("urun_tx_zero", q_tx_data[0], 0);
        chk("urun_tx_zero_cycle", q_tx_cyc[0], rc + 1);
        chk("urun_late_data", q_tx_data[1], 8'hC7);
        chk("urun_late_cycle", q_tx_cyc[1], vc + 1);
        chk("urun_no_timeout", tmo_flag, 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("urun_flag_cleared", urun_flag, 0);
        end_frame();

        // CSEL drop mid-byte in a write frame
        clear_q();
        start_frame();
        send_byte(8'h0C, c);
        repeat (3) tick();
        end_frame();
        chk("drop_no_write", q_wr_cyc.size(), 0);

        // CSEL drop during an outstanding read; late valid must not load
        clear_q();
        start_frame();
        send_byte(8'h90, c);
        wait_rd(ok);
        tick();
        csel_active = 1'b0;
        repeat (2) tick();
        rd_data = 8'h77; rd_valid = 1'b1;
        tick();
        rd_valid = 1'b0;
        repeat (3) tick();
        chk("drop_rd_no_load", q_tx_cyc.size(), 0);
        chk("drop_rd_frames", frame_count, exp_frames);

        // CSel_Start with a byte in the same cycle: the byte is dropped
        clear_q();
        start_frame();
        send_byte(8'h0A, c);
        tick();
        csel_start = 1'b1; rx_byte = 8'h85; rx_valid = 1'b1;
        tick();
        csel_start = 1'b0; rx_valid = 1'b0;
        exp_frames = (exp_frames + 1) % 256;
        tick();
        send_byte(8'h20, c);
        tick();
        send_byte(8'h5C, rc);
        tick();
        end_frame();
        chk("collide_wr_count", q_wr_cyc.size(), 1);
        chk("collide_wr_addr", q_wr_addr[0], 8'h20);
        chk("collide_wr_data", q_wr_data[0], 8'h5C);
        chk("collide_no_rd", q_rd_cyc.size(), 0);

        chk("never_wr_and_rd", n_both, 0);
        chk("tx_load_only_in_frame", n_txoff, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
